// File: rtl/render_tile_row.sv
// render_tile_row: composes one row of PIXELS pixels from a background tile
// and NUM_SPRITES sprite channels and streams it to VGA RAM, one pixel per clock.
module render_tile_row #(
    parameter int PIXELS      = 8,
    parameter int NUM_SPRITES = 2,
    parameter int SCREEN_W    = 256,
    parameter int SCREEN_H    = 240
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [8:0]                  vga_start_row,
    input  logic [8:0]                  vga_start_col,
    input  logic [PIXELS-1:0]           bg_pattern_low,
    input  logic [PIXELS-1:0]           bg_pattern_high,
    input  logic [31:0]                 bg_colors,
    input  logic [NUM_SPRITES*PIXELS-1:0] spr_pattern_low,
    input  logic [NUM_SPRITES*PIXELS-1:0] spr_pattern_high,
    input  logic [NUM_SPRITES*8-1:0]    spr_attr,
    input  logic [NUM_SPRITES*32-1:0]   spr_colors,
    input  logic [7:0]                  ppu_ctrl2,
    input  logic                        hit_clear,
    output logic [8:0]                  vga_addr_row,
    output logic [8:0]                  vga_addr_col,
    output logic [7:0]                  vga_data,
    output logic                        vga_write_en,
    output logic                        busy,
    output logic                        done,
    output logic                        sprite0_hit
);

    // Pixel counter is 4 bits wide because PIXELS never exceeds 16.
    localparam int KW = 4;
    localparam logic [KW-1:0] LAST_K     = KW'(PIXELS - 1);
    localparam logic [9:0]    SCREEN_W_L = 10'(SCREEN_W);
    localparam logic [8:0]    SCREEN_H_L = 9'(SCREEN_H);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t         state, state_next;
    logic [KW-1:0]  k, k_next;
    logic           load;
    logic           done_q, done_next;
    logic           hit_q;

    logic [8:0]                    row_q, col_q;
    logic [PIXELS-1:0]             bg_lo_q, bg_hi_q;
    logic [31:0]                   bg_colors_q;
    logic [NUM_SPRITES*PIXELS-1:0] spr_lo_q, spr_hi_q;
    logic [NUM_SPRITES*8-1:0]      spr_attr_q;
    logic [NUM_SPRITES*32-1:0]     spr_colors_q;
    logic [7:0]                    ctrl_q;

    logic [9:0]     col_c;
    logic [KW-1:0]  rev_k;
    logic [15:0]    bg_lo_ext, bg_hi_ext;
    logic [1:0]     bg_idx;
    logic           left_zone, bg_on, spr_on, bg_opaque, visible;
    logic [15:0]    s_lo, s_hi;
    logic [KW-1:0]  s_sel;
    logic [1:0]     s_idx;
    logic           win_found, win_behind, s0_opaque, hit_now;
    logic [7:0]     win_color, pix_color;

    // State, pixel counter and the registered done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            k      <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            k      <= k_next;
            done_q <= done_next;
        end
    end

    // Next-state logic: accept start only when idle, walk k across the row
    always_comb begin
        state_next = state;
        k_next     = k;
        load       = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = DRAW;
                    k_next     = '0;
                end
            end
            DRAW: begin
                if (k == LAST_K) begin
                    state_next = IDLE;
                    k_next     = '0;
                    done_next  = 1'b1;
                end else begin
                    k_next = k + 1'b1;
                end
            end
        endcase
    end

    // Snapshot every operand at start so upstream can move on immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q        <= '0;
            col_q        <= '0;
            bg_lo_q      <= '0;
            bg_hi_q      <= '0;
            bg_colors_q  <= '0;
            spr_lo_q     <= '0;
            spr_hi_q     <= '0;
            spr_attr_q   <= '0;
            spr_colors_q <= '0;
            ctrl_q       <= '0;
        end else if (load) begin
            row_q        <= vga_start_row;
            col_q        <= vga_start_col;
            bg_lo_q      <= bg_pattern_low;
            bg_hi_q      <= bg_pattern_high;
            bg_colors_q  <= bg_colors;
            spr_lo_q     <= spr_pattern_low;
            spr_hi_q     <= spr_pattern_high;
            spr_attr_q   <= spr_attr;
            spr_colors_q <= spr_colors;
            ctrl_q       <= ppu_ctrl2;
        end
    end

    // Pixel k: masking, sprite priority (lowest channel wins), colour pick, clipping
    always_comb begin
        col_c     = {1'b0, col_q} + {{(10-KW){1'b0}}, k};
        rev_k     = LAST_K - k;
        left_zone = (col_c < 10'd8);
        bg_on     = ctrl_q[3] && !(left_zone && !ctrl_q[1]);
        spr_on    = ctrl_q[4] && !(left_zone && !ctrl_q[2]);
        bg_lo_ext = 16'(bg_lo_q);
        bg_hi_ext = 16'(bg_hi_q);
        bg_idx    = {bg_hi_ext[rev_k], bg_lo_ext[rev_k]};
        bg_opaque = bg_on && (bg_idx != 2'd0);

        win_found  = 1'b0;
        win_behind = 1'b0;
        win_color  = 8'd0;
        s0_opaque  = 1'b0;
        s_lo       = '0;
        s_hi       = '0;
        s_sel      = '0;
        s_idx      = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            s_lo  = 16'(spr_lo_q[i*PIXELS +: PIXELS]);
            s_hi  = 16'(spr_hi_q[i*PIXELS +: PIXELS]);
            s_sel = spr_attr_q[i*8 + 6] ? k : rev_k;
            s_idx = {s_hi[s_sel], s_lo[s_sel]};
            if (spr_on && (s_idx != 2'd0)) begin
                win_found  = 1'b1;
                win_behind = spr_attr_q[i*8 + 5];
                win_color  = spr_colors_q[i*32 + 8*int'(s_idx) +: 8];
                if (i == 0) begin
                    s0_opaque = 1'b1;
                end
            end
        end

        if (win_found && (!win_behind || !bg_opaque)) begin
            pix_color = win_color;
        end else if (bg_opaque) begin
            pix_color = bg_colors_q[8*int'(bg_idx) +: 8];
        end else begin
            pix_color = bg_colors_q[7:0];
        end

        visible = (col_c < SCREEN_W_L) && (row_q < SCREEN_H_L);
        hit_now = (state == DRAW) && visible && s0_opaque && bg_opaque &&
                  (col_c <= 10'd254);
    end

    // Sticky sprite-0 hit; a clear wins over a set arriving in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q <= 1'b0;
        end else if (hit_clear) begin
            hit_q <= 1'b0;
        end else if (hit_now) begin
            hit_q <= 1'b1;
        end
    end

    assign busy         = (state == DRAW);
    assign done         = done_q;
    assign vga_write_en = busy && visible;
    assign vga_addr_row = busy ? row_q : 9'd0;
    assign vga_addr_col = busy ? col_c[8:0] : 9'd0;
    assign vga_data     = busy ? pix_color : 8'd0;
    assign sprite0_hit  = hit_q | (hit_now & ~hit_clear);

endmodule

// File: tb/tb_render_tile_row.sv
// tb_render_tile_row: scoreboard bench for render_tile_row with directed rows
// on a default instance and a PIXELS=16 / NUM_SPRITES=4 instance.
module tb_render_tile_row;

    typedef struct {
        logic       we;
        logic [8:0] row;
        logic [8:0] col;
        logic [7:0] data;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // default instance signals
    logic        start = 1'b0;
    logic [8:0]  vga_start_row = '0, vga_start_col = '0;
    logic [7:0]  bg_pattern_low = '0, bg_pattern_high = '0;
    logic [31:0] bg_colors = 32'h44332211;
    logic [15:0] spr_pattern_low = '0, spr_pattern_high = '0, spr_attr = '0;
    logic [63:0] spr_colors = 64'hCCBBAA99_88776655;
    logic [7:0]  ppu_ctrl2 = '0;
    logic        hit_clear = 1'b0;
    logic [8:0]  vga_addr_row, vga_addr_col;
    logic [7:0]  vga_data;
    logic        vga_write_en, busy, done, sprite0_hit;

    // wide instance signals
    logic         h_start = 1'b0;
    logic [15:0]  h_bg_lo = 16'hFF00, h_bg_hi = 16'h0F0F;
    logic [63:0]  h_spr_lo = {16'h00FF, 16'h0F00, 16'h0000, 16'h0000};
    logic [63:0]  h_spr_hi = '0;
    logic [31:0]  h_attr = 32'h20000000;
    logic [127:0] h_spr_colors = {32'h0000A300, 32'h0000A200, 32'h0000A100, 32'h0000A000};
    logic [8:0]   h_addr_row, h_addr_col;
    logic [7:0]   h_data;
    logic         h_we, h_busy, h_done, h_hit;

    int   total = 0;
    int   bad = 0;
    pix_t q[$];
    pix_t q16[$];
    pix_t exp8, exp16;

    render_tile_row dut (
        .clk(clk), .rst(rst), .start(start),
        .vga_start_row(vga_start_row), .vga_start_col(vga_start_col),
        .bg_pattern_low(bg_pattern_low), .bg_pattern_high(bg_pattern_high),
        .bg_colors(bg_colors),
        .spr_pattern_low(spr_pattern_low), .spr_pattern_high(spr_pattern_high),
        .spr_attr(spr_attr), .spr_colors(spr_colors),
        .ppu_ctrl2(ppu_ctrl2), .hit_clear(hit_clear),
        .vga_addr_row(vga_addr_row), .vga_addr_col(vga_addr_col),
        .vga_data(vga_data), .vga_write_en(vga_write_en),
        .busy(busy), .done(done), .sprite0_hit(sprite0_hit)
    );

    render_tile_row #(.PIXELS(16), .NUM_SPRITES(4)) dut16 (
        .clk(clk), .rst(rst), .start(h_start),
        .vga_start_row(9'd5), .vga_start_col(9'd100),
        .bg_pattern_low(h_bg_lo), .bg_pattern_high(h_bg_hi),
        .bg_colors(32'h44332211),
        .spr_pattern_low(h_spr_lo), .spr_pattern_high(h_spr_hi),
        .spr_attr(h_attr), .spr_colors(h_spr_colors),
        .ppu_ctrl2(8'h18), .hit_clear(1'b0),
        .vga_addr_row(h_addr_row), .vga_addr_col(h_addr_col),
        .vga_data(h_data), .vga_write_en(h_we),
        .busy(h_busy), .done(h_done), .sprite0_hit(h_hit)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    task automatic pushPix(input logic we, input logic [8:0] row,
                           input logic [8:0] col, input logic [7:0] data);
        pix_t p;
        p.we = we; p.row = row; p.col = col; p.data = data;
        q.push_back(p);
    endtask

    // Monitor for the default instance: every busy cycle pops one expected pixel
    always @(negedge clk) begin
        if (busy) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pixel: got col %0d with empty queue", vga_addr_col);
            end else begin
                exp8 = q.pop_front();
                checkOutput("pix_we", vga_write_en, exp8.we);
                if (exp8.we) begin
                    checkOutput("pix_row", vga_addr_row, exp8.row);
                    checkOutput("pix_col", vga_addr_col, exp8.col);
                    checkOutput("pix_data", vga_data, exp8.data);
                end
            end
        end
    end

    // Monitor for the wide instance
    always @(negedge clk) begin
        if (h_busy) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pixel16: got col %0d with empty queue", h_addr_col);
            end else begin
                exp16 = q16.pop_front();
                checkOutput("pix16_we", h_we, exp16.we);
                checkOutput("pix16_col", h_addr_col, exp16.col);
                checkOutput("pix16_data", h_data, exp16.data);
            end
        end
    end

    task automatic applyStimulus(input logic [8:0] row, input logic [8:0] col,
                                 input logic [7:0] ctrl, input logic [7:0] bglo,
                                 input logic [15:0] sprlo, input logic [15:0] attr);
        @(negedge clk);
        vga_start_row   = row;
        vga_start_col   = col;
        ppu_ctrl2       = ctrl;
        bg_pattern_low  = bglo;
        bg_pattern_high = 8'h00;
        spr_pattern_low = sprlo;
        spr_attr        = attr;
        start           = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Walk the PIXELS+1 cycles after start: busy, done and per-cycle hit
    task automatic checkRow(input logic [7:0] expHit, input logic repulse);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            checkOutput("busy", busy, (n <= 8));
            checkOutput("done", done, (n == 9));
            if (n <= 8) checkOutput("hit", sprite0_hit, expHit[n-1]);
            if (repulse && n == 3) begin
                start          = 1'b1;
                bg_pattern_low = ~bg_pattern_low;
                vga_start_col  = 9'd100;
            end
            if (repulse && n == 4) start = 1'b0;
        end
        if (repulse) begin
            @(negedge clk);
            checkOutput("busy_after_repulse", busy, 1'b0);
        end
    endtask

    task automatic clearHit();
        @(negedge clk);
        hit_clear = 1'b1;
        @(posedge clk);
        #1 hit_clear = 1'b0;
        checkOutput("hit_cleared", sprite0_hit, 1'b0);
    endtask

    initial begin
        $display("[TB] render_tile_row bench starting");
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_we", vga_write_en, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_hit", sprite0_hit, 1'b0);
        checkOutput("rst_data", vga_data, 8'h00);
        rst = 1'b1;

        // background only, left columns shown
        for (int k = 0; k < 8; k++) pushPix(1'b1, 9'd10, 9'(16 + k), (k < 4) ? 8'h22 : 8'h11);
        applyStimulus(9'd10, 9'd16, 8'h0A, 8'hF0, 16'h0000, 16'h0000);
        checkRow(8'h00, 1'b0);

        // priority between channels and horizontal flip on channel 0
        for (int k = 0; k < 8; k++) pushPix(1'b1, 9'd20, 9'(32 + k), (k == 0) ? 8'h66 : 8'hAA);
        applyStimulus(9'd20, 9'd32, 8'h18, 8'h00, 16'hFF01, 16'h0040);
        checkRow(8'h00, 1'b0);

        // behind-background sprite with opaque background: background shows, hit set
        for (int k = 0; k < 8; k++) pushPix(1'b1, 9'd30, 9'(40 + k), 8'h22);
        applyStimulus(9'd30, 9'd40, 8'h18, 8'hFF, 16'h00FF, 16'h0020);
        checkRow(8'hFF, 1'b0);
        clearHit();

        // behind-background sprite over transparent background: sprite shows, no hit
        for (int k = 0; k < 8; k++) pushPix(1'b1, 9'd30, 9'(40 + k), 8'h66);
        applyStimulus(9'd30, 9'd40, 8'h18, 8'h00, 16'h00FF, 16'h0020);
        checkRow(8'h00, 1'b0);

        // left-column masking: backdrop in columns 4-7, hit only from column 8
        for (int k = 0; k < 8; k++) pushPix(1'b1, 9'd50, 9'(4 + k), (k < 4) ? 8'h11 : 8'h66);
        applyStimulus(9'd50, 9'd4, 8'h18, 8'hFF, 16'h00FF, 16'h0000);
        checkRow(8'hF0, 1'b0);
        clearHit();

        // right-edge clipping: four writes then four suppressed cycles
        for (int k = 0; k < 8; k++) pushPix((k < 4), 9'd60, 9'(252 + k), 8'h22);
        applyStimulus(9'd60, 9'd252, 8'h0A, 8'hF0, 16'h0000, 16'h0000);
        checkRow(8'h00, 1'b0);

        // bottom clipping: nothing written, done still pulses
        for (int k = 0; k < 8; k++) pushPix(1'b0, 9'd240, 9'(16 + k), 8'h00);
        applyStimulus(9'd240, 9'd16, 8'h0A, 8'hF0, 16'h0000, 16'h0000);
        checkRow(8'h00, 1'b0);

        // start re-pulsed mid-row with different operands is ignored
        for (int k = 0; k < 8; k++) pushPix(1'b1, 9'd12, 9'(16 + k), (k < 4) ? 8'h22 : 8'h11);
        applyStimulus(9'd12, 9'd16, 8'h0A, 8'hF0, 16'h0000, 16'h0000);
        checkRow(8'h00, 1'b1);

        // hit_clear held across a colliding row keeps the flag low
        hit_clear = 1'b1;
        for (int k = 0; k < 8; k++) pushPix(1'b1, 9'd80, 9'(40 + k), 8'h22);
        applyStimulus(9'd80, 9'd40, 8'h18, 8'hFF, 16'h00FF, 16'h0020);
        checkRow(8'h00, 1'b0);
        hit_clear = 1'b0;
        @(negedge clk);
        checkOutput("hit_after_clear_row", sprite0_hit, 1'b0);

        // reset mid-row: outputs drop at once, no done afterwards
        for (int k = 0; k < 3; k++) pushPix(1'b1, 9'd70, 9'(40 + k), 8'h66);
        applyStimulus(9'd70, 9'd40, 8'h18, 8'hFF, 16'h00FF, 16'h0000);
        repeat (3) @(negedge clk);
        checkOutput("hit_before_reset", sprite0_hit, 1'b1);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_we", vga_write_en, 1'b0);
        checkOutput("mid_rst_data", vga_data, 8'h00);
        checkOutput("mid_rst_col", vga_addr_col, 9'd0);
        checkOutput("mid_rst_row", vga_addr_row, 9'd0);
        checkOutput("mid_rst_hit", sprite0_hit, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checkOutput("no_done_after_reset", done, 1'b0);
        end
        checkOutput("queue_empty", q.size(), 0);

        // wide instance: 16 pixels, 4 channels, behind-priority on channel 3
        for (int k = 0; k < 16; k++) begin
            exp16.we  = 1'b1;
            exp16.row = 9'd5;
            exp16.col = 9'(100 + k);
            exp16.data = (k < 4) ? 8'h22 : (k < 8) ? 8'hA2 : (k < 12) ? 8'hA3 : 8'h33;
            q16.push_back(exp16);
        end
        @(negedge clk);
        h_start = 1'b1;
        @(posedge clk);
        #1 h_start = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            checkOutput("busy16", h_busy, (n <= 16));
            checkOutput("done16", h_done, (n == 17));
        end
        checkOutput("hit16", h_hit, 1'b0);
        checkOutput("queue16_empty", q16.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
